// File: rtl/dcache_flush_unit_pkg.sv
// dcache_flush_unit_pkg
//   Shared types for the D$ flush/init unit.
//   dcache_flush_state_e : walker FSM states
//   dcache_tag_status_t  : status bits returned by a tag read
package dcache_flush_unit_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    READ,
    CHECK,
    WB,
    WB_WAIT,
    INVAL,
    ACK
  } dcache_flush_state_e;

  typedef struct packed {
    logic valid;
    logic dirty;
  } dcache_tag_status_t;

endpackage

// File: rtl/dcache_flush_unit_counter.sv
// dcache_flush_unit_counter
//   Generic W-bit up-counter with synchronous clear. Wraps to 0 after all-ones.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : force count to 0 (wins over en_i)
//   en_i          : increment
//   cnt_o         : current count (registered)
//   max_o         : count is all-ones, i.e. the next increment overflows
module dcache_flush_unit_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         max_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign max_o = &cnt_q;

endmodule

// File: rtl/dcache_flush_unit.sv
// dcache_flush_unit
//   Walks every (set, way) of the D$: after reset it invalidates all lines
//   (unless no_init_i), and on a flush request it reads each tag, writes back
//   valid dirty lines, invalidates valid lines and pulses flush_ack_o.
//   Controller side : flush_i, flush_ack_o, busy_o, no_init_i
//   Tag array side  : tag_req_o/tag_gnt_i, tag_we_o, tag_idx_o, tag_way_o,
//                     tag_rvalid_i, tag_valid_i, tag_dirty_i
//   Writeback side  : wb_req_o/wb_gnt_i, wb_done_i
//   All outputs are registered; address comes straight from the line counter.
module dcache_flush_unit
  import dcache_flush_unit_pkg::*;
#(
  parameter  int NR_SETS = 256,
  parameter  int NR_WAYS = 8,
  localparam int IDX_W   = $clog2(NR_SETS),
  localparam int WAY_W   = $clog2(NR_WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  output logic             flush_ack_o,
  output logic             busy_o,
  input  logic             no_init_i,
  output logic             tag_req_o,
  input  logic             tag_gnt_i,
  output logic             tag_we_o,
  output logic [IDX_W-1:0] tag_idx_o,
  output logic [WAY_W-1:0] tag_way_o,
  input  logic             tag_rvalid_i,
  input  logic             tag_valid_i,
  input  logic             tag_dirty_i,
  output logic             wb_req_o,
  input  logic             wb_gnt_i,
  input  logic             wb_done_i
);

  localparam int LINE_W = IDX_W + WAY_W;

  dcache_flush_state_e state_d, state_q;
  logic tag_req_d, tag_req_q;
  logic tag_we_d, tag_we_q;
  logic wb_req_d, wb_req_q;
  logic ack_d, ack_q;
  logic busy_d, busy_q;
  logic pend_d, pend_q;      // flush seen while still initialising
  logic wb_out_d, wb_out_q;  // writeback granted, completion not yet seen

  logic              cnt_clr, cnt_en, last_line;
  logic [LINE_W-1:0] line;
  dcache_tag_status_t tag_st;

  assign tag_st = '{valid: tag_valid_i, dirty: tag_dirty_i};

  // {idx, way} pointer: way is the low field so it is the inner loop.
  dcache_flush_unit_counter #(.W(LINE_W)) u_line_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (line),
    .max_o (last_line)
  );

  always_comb begin
    state_d   = state_q;
    tag_req_d = 1'b0;
    tag_we_d  = 1'b0;
    wb_req_d  = 1'b0;
    ack_d     = 1'b0;
    pend_d    = pend_q;
    wb_out_d  = wb_out_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      INIT: begin
        if (flush_i) pend_d = 1'b1;
        // tag_req_q low only in the first INIT cycle: decide skip vs. walk.
        if (!tag_req_q) begin
          if (no_init_i) state_d = IDLE;
          else begin
            tag_req_d = 1'b1;
            tag_we_d  = 1'b1;
          end
        end else if (tag_gnt_i) begin
          cnt_en = 1'b1;
          if (last_line) state_d = IDLE;
          else begin
            tag_req_d = 1'b1;
            tag_we_d  = 1'b1;
          end
        end else begin
          tag_req_d = 1'b1;
          tag_we_d  = 1'b1;
        end
      end
      IDLE: begin
        if (flush_i || pend_q) begin
          state_d   = READ;
          pend_d    = 1'b0;
          cnt_clr   = 1'b1;
          tag_req_d = 1'b1;
        end
      end
      READ: begin
        if (tag_gnt_i) state_d = CHECK;
        else           tag_req_d = 1'b1;
      end
      CHECK: begin
        if (tag_rvalid_i) begin
          if (tag_st.valid && tag_st.dirty) begin
            state_d  = WB;
            wb_req_d = 1'b1;
          end else if (tag_st.valid) begin
            state_d   = INVAL;
            tag_req_d = 1'b1;
            tag_we_d  = 1'b1;
          end else begin
            cnt_en = 1'b1;
            if (last_line) begin
              state_d = ACK;
              ack_d   = 1'b1;
            end else begin
              state_d   = READ;
              tag_req_d = 1'b1;
            end
          end
        end
      end
      WB: begin
        if (wb_gnt_i) begin
          // completion may coincide with the grant
          if (wb_done_i) begin
            state_d   = INVAL;
            tag_req_d = 1'b1;
            tag_we_d  = 1'b1;
          end else begin
            state_d  = WB_WAIT;
            wb_out_d = 1'b1;
          end
        end else begin
          wb_req_d = 1'b1;
        end
      end
      WB_WAIT: begin
        if (wb_done_i) begin
          state_d   = INVAL;
          wb_out_d  = 1'b0;
          tag_req_d = 1'b1;
          tag_we_d  = 1'b1;
        end
      end
      INVAL: begin
        if (tag_gnt_i) begin
          cnt_en = 1'b1;
          if (last_line) begin
            state_d = ACK;
            ack_d   = 1'b1;
          end else begin
            state_d   = READ;
            tag_req_d = 1'b1;
          end
        end else begin
          tag_req_d = 1'b1;
          tag_we_d  = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = INIT;
    endcase
    busy_d = !(state_d inside {IDLE, ACK}) || wb_out_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= INIT;
      tag_req_q <= 1'b0;
      tag_we_q  <= 1'b0;
      wb_req_q  <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      pend_q    <= 1'b0;
      wb_out_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tag_req_q <= tag_req_d;
      tag_we_q  <= tag_we_d;
      wb_req_q  <= wb_req_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      wb_out_q  <= wb_out_d;
    end
  end

  assign tag_req_o   = tag_req_q;
  assign tag_we_o    = tag_we_q;
  assign tag_idx_o   = line[LINE_W-1:WAY_W];
  assign tag_way_o   = line[WAY_W-1:0];
  assign wb_req_o    = wb_req_q;
  assign flush_ack_o = ack_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_dcache_flush_unit.sv
// tb_dcache_flush_unit
//   Drives dcache_flush_unit (4 sets x 2 ways) against a small tag-array /
//   writeback responder model. Expected tag/writeback handshakes are queued
//   when a scenario starts and checked in order as the DUT performs them.
module tb_dcache_flush_unit;

  localparam int NR_SETS = 4;
  localparam int NR_WAYS = 2;
  localparam int IDX_W   = 2;
  localparam int WAY_W   = 1;
  localparam int NL      = NR_SETS * NR_WAYS;

  localparam logic [1:0] K_RD  = 2'd0;
  localparam logic [1:0] K_INV = 2'd1;
  localparam logic [1:0] K_WB  = 2'd2;

  typedef struct packed {
    logic [1:0]       kind;
    logic [IDX_W-1:0] idx;
    logic [WAY_W-1:0] way;
  } ev_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i = 1'b0, no_init_i = 1'b0;
  logic tag_gnt_i = 1'b0, tag_rvalid_i = 1'b0, tag_valid_i = 1'b0, tag_dirty_i = 1'b0;
  logic wb_gnt_i = 1'b0, wb_done_i = 1'b0;
  logic flush_ack_o, busy_o, tag_req_o, tag_we_o, wb_req_o;
  logic [IDX_W-1:0] tag_idx_o;
  logic [WAY_W-1:0] tag_way_o;

  always #5 clk_i = ~clk_i;

  dcache_flush_unit #(.NR_SETS(NR_SETS), .NR_WAYS(NR_WAYS)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .flush_ack_o (flush_ack_o),
    .busy_o      (busy_o),
    .no_init_i   (no_init_i),
    .tag_req_o   (tag_req_o),
    .tag_gnt_i   (tag_gnt_i),
    .tag_we_o    (tag_we_o),
    .tag_idx_o   (tag_idx_o),
    .tag_way_o   (tag_way_o),
    .tag_rvalid_i(tag_rvalid_i),
    .tag_valid_i (tag_valid_i),
    .tag_dirty_i (tag_dirty_i),
    .wb_req_o    (wb_req_o),
    .wb_gnt_i    (wb_gnt_i),
    .wb_done_i   (wb_done_i)
  );

  ev_t exp_q[$];
  int  n_cmp = 0, n_err = 0;
  int  ack_cnt = 0, wb_cnt = 0, rd_cnt = 0, inv_cnt = 0;
  bit  mdl_valid[NL];
  bit  mdl_dirty[NL];
  int  tag_dly = 0, wbg_dly = 0, wbd_dly = 0;

  // ---------------- tag array responder ----------------
  initial begin : tag_resp
    int wait_c, rv_c, rd_line, ln;
    wait_c = 0; rv_c = 0; rd_line = 0;
    forever begin
      @(negedge clk_i);
      tag_gnt_i    = 1'b0;
      tag_rvalid_i = 1'b0;
      if (!rst_ni) begin
        wait_c = 0;
        rv_c   = 0;
      end else begin
        if (rv_c > 0) begin
          rv_c--;
          if (rv_c == 0) begin
            tag_rvalid_i = 1'b1;
            tag_valid_i  = mdl_valid[rd_line];
            tag_dirty_i  = mdl_dirty[rd_line];
          end
        end
        if (tag_req_o) begin
          if (wait_c >= tag_dly) begin
            tag_gnt_i = 1'b1;
            wait_c    = 0;
            ln = int'(tag_idx_o) * NR_WAYS + int'(tag_way_o);
            if (tag_we_o) begin
              mdl_valid[ln] = 1'b0;
              mdl_dirty[ln] = 1'b0;
            end else begin
              rd_line = ln;
              rv_c    = 1;
            end
          end else wait_c++;
        end
      end
    end
  end

  // ---------------- writeback responder ----------------
  initial begin : wb_resp
    int wait_c, done_c;
    wait_c = 0; done_c = -1;
    forever begin
      @(negedge clk_i);
      wb_gnt_i  = 1'b0;
      wb_done_i = 1'b0;
      if (!rst_ni) begin
        wait_c = 0;
        done_c = -1;
      end else begin
        if (done_c > 0) begin
          done_c--;
          if (done_c == 0) begin
            wb_done_i = 1'b1;
            done_c    = -1;
          end
        end
        if (wb_req_o) begin
          if (wait_c >= wbg_dly) begin
            wb_gnt_i = 1'b1;
            wait_c   = 0;
            if (wbd_dly == 0) wb_done_i = 1'b1;
            else              done_c = wbd_dly;
          end else wait_c++;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    bit   t_stall, w_stall;
    logic [IDX_W+WAY_W+1:0] t_vec, w_vec;
    ev_t  got, exp;
    t_stall = 0; w_stall = 0; t_vec = '0; w_vec = '0;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_ni) begin
        t_stall = 0;
        w_stall = 0;
      end else begin
        if (t_stall) begin
          n_cmp++;
          if ({tag_req_o, tag_we_o, tag_idx_o, tag_way_o} !== t_vec) begin
            n_err++;
            $display("FAIL tag_hold: got %0h expected %0h", {tag_req_o, tag_we_o, tag_idx_o, tag_way_o}, t_vec);
          end
        end
        if (w_stall) begin
          n_cmp++;
          if ({wb_req_o, 1'b0, tag_idx_o, tag_way_o} !== w_vec) begin
            n_err++;
            $display("FAIL wb_hold: got %0h expected %0h", {wb_req_o, 1'b0, tag_idx_o, tag_way_o}, w_vec);
          end
        end
        t_stall = tag_req_o && !tag_gnt_i;
        t_vec   = {tag_req_o, tag_we_o, tag_idx_o, tag_way_o};
        w_stall = wb_req_o && !wb_gnt_i;
        w_vec   = {wb_req_o, 1'b0, tag_idx_o, tag_way_o};
        if (tag_req_o && tag_gnt_i) begin
          got = '{kind: (tag_we_o ? K_INV : K_RD), idx: tag_idx_o, way: tag_way_o};
          if (tag_we_o) inv_cnt++; else rd_cnt++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL tag_seq: got %0h expected none", got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              n_err++;
              $display("FAIL tag_seq: got %0h expected %0h", got, exp);
            end
          end
        end
        if (wb_req_o && wb_gnt_i) begin
          got = '{kind: K_WB, idx: tag_idx_o, way: tag_way_o};
          wb_cnt++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL wb_seq: got %0h expected none", got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              n_err++;
              $display("FAIL wb_seq: got %0h expected %0h", got, exp);
            end
          end
        end
        if (flush_ack_o) ack_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk_i);
    #3;
  endtask

  task automatic clr_counts();
    ack_cnt = 0; wb_cnt = 0; rd_cnt = 0; inv_cnt = 0;
  endtask

  task automatic push_ev(input logic [1:0] k, input int l);
    ev_t e;
    e.kind = k;
    e.idx  = IDX_W'(l / NR_WAYS);
    e.way  = WAY_W'(l % NR_WAYS);
    exp_q.push_back(e);
  endtask

  // Expected flush walk derived from the current model contents.
  task automatic push_walk();
    for (int l = 0; l < NL; l++) begin
      push_ev(K_RD, l);
      if (mdl_valid[l] && mdl_dirty[l]) push_ev(K_WB, l);
      if (mdl_valid[l]) push_ev(K_INV, l);
    end
  endtask

  task automatic set_model(input bit v, input bit d);
    for (int l = 0; l < NL; l++) begin
      mdl_valid[l] = v;
      mdl_dirty[l] = d;
    end
  endtask

  task automatic apply_reset(input bit ni);
    @(negedge clk_i);
    rst_ni    = 1'b0;
    flush_i   = 1'b0;
    no_init_i = ni;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic drive_flush(output bit acked, output logic busy_after);
    acked   = 1'b0;
    flush_i = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (flush_ack_o) begin
        acked   = 1'b1;
        flush_i = 1'b0;
        break;
      end
    end
    flush_i = 1'b0;
    tick();
    busy_after = busy_o;
    repeat (4) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({tag_req_o, tag_we_o, tag_idx_o, tag_way_o, wb_req_o, flush_ack_o, busy_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {tag_req_o, tag_we_o, tag_idx_o, tag_way_o, wb_req_o, flush_ack_o, busy_o});
    end
  endtask

  task automatic test_init();
    int drops, still_valid;
    drops = 0; still_valid = 0;
    set_model(1'b1, 1'b1);
    tag_dly = 0;
    exp_q.delete();
    for (int l = 0; l < NL; l++) push_ev(K_INV, l);
    clr_counts();
    no_init_i = 1'b0;
    rst_ni    = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (exp_q.size() == 0) break;
      if (!busy_o) drops++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL init_done: got %0d left expected 0", exp_q.size());
    end
    n_cmp++;
    if (drops != 0) begin
      n_err++;
      $display("FAIL init_busy: got %0d low cycles expected 0", drops);
    end
    repeat (5) tick();
    for (int l = 0; l < NL; l++) if (mdl_valid[l]) still_valid++;
    n_cmp++;
    if (still_valid != 0) begin
      n_err++;
      $display("FAIL init_lines: got %0d valid expected 0", still_valid);
    end
    n_cmp++;
    if ({ack_cnt, inv_cnt} !== {32'd0, 32'd8}) begin
      n_err++;
      $display("FAIL init_counts: got ack %0d inv %0d expected ack 0 inv 8", ack_cnt, inv_cnt);
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL init_idle_busy: got %0b expected 0", busy_o);
    end
  endtask

  task automatic test_no_init();
    int reqs, busys;
    reqs = 0; busys = 0;
    exp_q.delete();
    clr_counts();
    apply_reset(1'b1);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tag_req_o) reqs++;
      if (busy_o) busys++;
    end
    n_cmp++;
    if (reqs != 0) begin
      n_err++;
      $display("FAIL noinit_req: got %0d expected 0", reqs);
    end
    n_cmp++;
    if (busys != 0) begin
      n_err++;
      $display("FAIL noinit_busy: got %0d expected 0", busys);
    end
  endtask

  task automatic test_flush_invalid();
    bit acked;
    logic busy_after;
    set_model(1'b0, 1'b0);
    tag_dly = 0; wbg_dly = 0; wbd_dly = 0;
    exp_q.delete();
    push_walk();
    clr_counts();
    drive_flush(acked, busy_after);
    n_cmp++;
    if (!acked) begin
      n_err++;
      $display("FAIL inv_ack: got none expected ack");
    end
    n_cmp++;
    if (busy_after !== 1'b0) begin
      n_err++;
      $display("FAIL inv_busy_after: got %0b expected 0", busy_after);
    end
    n_cmp++;
    if ({ack_cnt, rd_cnt, inv_cnt, wb_cnt} !== {32'd1, 32'd8, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL inv_counts: got ack %0d rd %0d inv %0d wb %0d expected 1 8 0 0",
               ack_cnt, rd_cnt, inv_cnt, wb_cnt);
    end
  endtask

  task automatic test_flush_mixed();
    bit acked;
    logic busy_after;
    set_model(1'b0, 1'b0);
    mdl_valid[0] = 1'b1;
    mdl_valid[5] = 1'b1;
    mdl_dirty[5] = 1'b1;
    tag_dly = 0; wbg_dly = 0; wbd_dly = 2;
    exp_q.delete();
    push_walk();
    clr_counts();
    drive_flush(acked, busy_after);
    n_cmp++;
    if (!acked || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL mix_done: got ack %0b left %0d expected ack 1 left 0", acked, exp_q.size());
    end
    n_cmp++;
    if ({ack_cnt, rd_cnt, inv_cnt, wb_cnt} !== {32'd1, 32'd8, 32'd2, 32'd1}) begin
      n_err++;
      $display("FAIL mix_counts: got ack %0d rd %0d inv %0d wb %0d expected 1 8 2 1",
               ack_cnt, rd_cnt, inv_cnt, wb_cnt);
    end
    n_cmp++;
    if (busy_after !== 1'b0) begin
      n_err++;
      $display("FAIL mix_busy_after: got %0b expected 0", busy_after);
    end
  endtask

  task automatic test_backpressure();
    bit acked;
    logic busy_after;
    set_model(1'b0, 1'b0);
    mdl_valid[2] = 1'b1;
    mdl_dirty[2] = 1'b1;
    mdl_valid[7] = 1'b1;
    tag_dly = 5; wbg_dly = 3; wbd_dly = 10;
    exp_q.delete();
    push_walk();
    clr_counts();
    drive_flush(acked, busy_after);
    n_cmp++;
    if (!acked || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_done: got ack %0b left %0d expected ack 1 left 0", acked, exp_q.size());
    end
    n_cmp++;
    if ({ack_cnt, rd_cnt, inv_cnt, wb_cnt} !== {32'd1, 32'd8, 32'd2, 32'd1}) begin
      n_err++;
      $display("FAIL bp_counts: got ack %0d rd %0d inv %0d wb %0d expected 1 8 2 1",
               ack_cnt, rd_cnt, inv_cnt, wb_cnt);
    end
    tag_dly = 0; wbg_dly = 0; wbd_dly = 0;
  endtask

  task automatic test_pending_and_reset();
    bit acked;
    // phase 1: short flush pulse during init must be remembered
    set_model(1'b1, 1'b0);
    tag_dly = 1; wbg_dly = 0; wbd_dly = 0;
    exp_q.delete();
    for (int l = 0; l < NL; l++) push_ev(K_INV, l);
    for (int l = 0; l < NL; l++) push_ev(K_RD, l);
    clr_counts();
    apply_reset(1'b0);
    repeat (2) tick();
    flush_i = 1'b1;
    repeat (2) tick();
    flush_i = 1'b0;
    acked = 1'b0;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (flush_ack_o) begin
        acked = 1'b1;
        break;
      end
    end
    repeat (3) tick();
    n_cmp++;
    if (!acked || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pend_done: got ack %0b left %0d expected ack 1 left 0", acked, exp_q.size());
    end
    n_cmp++;
    if ({ack_cnt, rd_cnt, inv_cnt} !== {32'd1, 32'd8, 32'd8}) begin
      n_err++;
      $display("FAIL pend_counts: got ack %0d rd %0d inv %0d expected 1 8 8", ack_cnt, rd_cnt, inv_cnt);
    end

    // phase 2: reset while a writeback is outstanding
    mdl_valid[3] = 1'b1;
    mdl_dirty[3] = 1'b1;
    tag_dly = 0; wbd_dly = 50;
    exp_q.delete();
    for (int l = 0; l < 4; l++) push_ev(K_RD, l);
    push_ev(K_WB, 3);
    clr_counts();
    flush_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (wb_cnt != 0) break;
    end
    repeat (2) tick();
    n_cmp++;
    if ({busy_o, wb_cnt, exp_q.size()} !== {1'b1, 32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL wbwait_state: got busy %0b wb %0d left %0d expected 1 1 0", busy_o, wb_cnt, exp_q.size());
    end
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    #1;
    n_cmp++;
    if ({tag_req_o, tag_we_o, tag_idx_o, tag_way_o, wb_req_o, flush_ack_o, busy_o} !== '0) begin
      n_err++;
      $display("FAIL midwalk_reset: got %0h expected 0",
               {tag_req_o, tag_we_o, tag_idx_o, tag_way_o, wb_req_o, flush_ack_o, busy_o});
    end
    exp_q.delete();
    for (int l = 0; l < NL; l++) push_ev(K_INV, l);
    clr_counts();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (exp_q.size() == 0) break;
    end
    repeat (5) tick();
    n_cmp++;
    if ({exp_q.size(), inv_cnt, rd_cnt, wb_cnt, ack_cnt} !== {32'd0, 32'd8, 32'd0, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL reinit: got left %0d inv %0d rd %0d wb %0d ack %0d expected 0 8 0 0 0",
               exp_q.size(), inv_cnt, rd_cnt, wb_cnt, ack_cnt);
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reinit_busy: got %0b expected 0", busy_o);
    end
  endtask

  initial begin : main
    test_reset();
    test_init();
    test_no_init();
    test_flush_invalid();
    test_flush_mixed();
    test_backpressure();
    test_pending_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
